// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown controller: FSM states and BCD digit arithmetic.
package countdown_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    PAUSE,
    ALARM
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd2_t;

  localparam bcd_t       BCD_MAX_UNITS = 4'd9;
  localparam logic [7:0] ENTRY_MAX     = 8'h50;

  // Two-digit BCD decrement; units borrow wraps to 9 and takes one from tens.
  function automatic bcd2_t bcd2_dec(input bcd2_t v);
    bcd2_t r;
    if (v.units == 4'd0) begin
      r.units = BCD_MAX_UNITS;
      r.tens  = v.tens - 4'd1;
    end else begin
      r.units = v.units - 4'd1;
      r.tens  = v.tens;
    end
    return r;
  endfunction

  function automatic logic bcd2_is_zero(input bcd2_t v);
    return (v.tens == 4'd0) && (v.units == 4'd0);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV enabled cycles, plus a 2 Hz phase for the alarm.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick_c,
  output logic phase_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] Q1   = CNT_W'(CLK_DIV / 4);
  localparam logic [CNT_W-1:0] Q2   = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] Q3   = CNT_W'((3 * CLK_DIV) / 4);

  logic [CNT_W-1:0] cnt;

  // Clear wins over enable; the count holds while disabled so a pause resumes mid-second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick_c  = en && !clr && (cnt == LAST);
  assign phase_c = (cnt < Q1) || ((cnt >= Q2) && (cnt < Q3));

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: loads a BCD entry, counts it down once per second, owns the speaker.
// Build option ALARM_PULSE_EN: alarm tone gated by a 2 Hz square wave instead of steady on.
module countdown_ctrl #(
  parameter int unsigned CLK_DIV      = 50_000_000,
  parameter int unsigned ERR_BEEP_CYC = 25_000_000,
  parameter int unsigned ALARM_SEC    = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       entry_ok,
  input  logic       entry_err,
  input  logic [3:0] ent_tens,
  input  logic [3:0] ent_units,
  input  logic       start_pause,
  input  logic       clear,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_units,
  output logic       running,
  output logic       done,
  output logic       speaker
);

  import countdown_pkg::*;

  localparam int unsigned BEEP_W = $clog2(ERR_BEEP_CYC + 1);
  localparam int unsigned ALM_W  = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(ERR_BEEP_CYC);
  localparam logic [ALM_W-1:0]  ALM_LAST  = ALM_W'(ALARM_SEC - 1);

  state_e            state, state_d;
  bcd2_t             cnt, cnt_d;
  bcd2_t             entry_c, dec_c;
  logic [BEEP_W-1:0] beep_cnt, beep_d;
  logic [ALM_W-1:0]  alm_cnt, alm_d;
  logic              done_d, running_d, speaker_d;
  logic [2:0]        ok_sync, err_sync;
  logic              ok_evt_c, err_evt_c;
  logic              presc_en_c, presc_clr_c, tick_c, alarm_phase_c, alarm_gate_c;

  // Two-flop synchronisers plus a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ok_sync  <= '0;
      err_sync <= '0;
    end else begin
      ok_sync  <= {ok_sync[1:0], entry_ok};
      err_sync <= {err_sync[1:0], entry_err};
    end
  end

  assign ok_evt_c  = ok_sync[1] && !ok_sync[2];
  assign err_evt_c = err_sync[1] && !err_sync[2];

  assign entry_c = {ent_tens, ent_units};
  assign dec_c   = bcd2_dec(cnt);

  // Prescaler runs in RUN and ALARM; it restarts on every start from ARMED and on clear.
  assign presc_en_c  = (state == RUN) || (state == ALARM);
  assign presc_clr_c = clear || ((state == ARMED) && start_pause);

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (presc_en_c),
    .clr     (presc_clr_c),
    .tick_c  (tick_c),
    .phase_c (alarm_phase_c)
  );

`ifdef ALARM_PULSE_EN
  assign alarm_gate_c = alarm_phase_c;
`else
  logic unused_phase;
  assign unused_phase = alarm_phase_c;
  assign alarm_gate_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      beep_cnt <= '0;
      alm_cnt  <= '0;
      done     <= 1'b0;
      running  <= 1'b0;
      speaker  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      beep_cnt <= beep_d;
      alm_cnt  <= alm_d;
      done     <= done_d;
      running  <= running_d;
      speaker  <= speaker_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    beep_d    = beep_cnt;
    alm_d     = alm_cnt;
    done_d    = 1'b0;
    running_d = 1'b0;
    speaker_d = 1'b0;

    // Error beep: a fresh edge (re)loads the timer unless the alarm owns the speaker.
    if (beep_cnt != '0) beep_d = beep_cnt - BEEP_W'(1);
    if (err_evt_c && (state != ALARM)) beep_d = BEEP_LOAD;

    unique case (state)
      IDLE: begin
        if (ok_evt_c) begin
          cnt_d   = entry_c;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (start_pause) begin
          // A loaded 00 has nothing to count: alarm straight away.
          if (bcd2_is_zero(cnt)) begin
            done_d  = 1'b1;
            alm_d   = '0;
            state_d = ALARM;
          end else begin
            state_d = RUN;
          end
        end else if (ok_evt_c) begin
          cnt_d = entry_c;
        end
      end
      RUN: begin
        if (tick_c) begin
          cnt_d = dec_c;
          if (bcd2_is_zero(dec_c)) begin
            done_d  = 1'b1;
            alm_d   = '0;
            state_d = ALARM;
          end
        end
        if (start_pause && (state_d == RUN)) state_d = PAUSE;
      end
      PAUSE: begin
        if (start_pause) state_d = RUN;
      end
      ALARM: begin
        if (start_pause) begin
          state_d = IDLE;
        end else if (tick_c) begin
          if (alm_cnt == ALM_LAST) state_d = IDLE;
          else                     alm_d   = alm_cnt + ALM_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == ALARM) beep_d = '0;

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      beep_d  = '0;
      alm_d   = '0;
      done_d  = 1'b0;
    end

    running_d = (state_d == RUN);
    speaker_d = ((state_d == ALARM) && alarm_gate_c) || (beep_d != '0);
  end

  assign cnt_tens  = cnt.tens;
  assign cnt_units = cnt.units;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl with CLK_DIV=4, ERR_BEEP_CYC=6, ALARM_SEC=2.
module tb_countdown_ctrl;

  localparam int unsigned CLK_DIV      = 4;
  localparam int unsigned ERR_BEEP_CYC = 6;
  localparam int unsigned ALARM_SEC    = 2;

  localparam logic [10:0] M_ALL = 11'h7FF;
  localparam logic [10:0] M_CR  = 11'h7FC;
  localparam logic [10:0] M_SPK = 11'h001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       entry_ok = 1'b0;
  logic       entry_err = 1'b0;
  logic [3:0] ent_tens = 4'd0;
  logic [3:0] ent_units = 4'd0;
  logic       start_pause = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] cnt_tens, cnt_units;
  logic       running, done, speaker;

  countdown_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .ERR_BEEP_CYC (ERR_BEEP_CYC),
    .ALARM_SEC    (ALARM_SEC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .entry_ok    (entry_ok),
    .entry_err   (entry_err),
    .ent_tens    (ent_tens),
    .ent_units   (ent_units),
    .start_pause (start_pause),
    .clear       (clear),
    .cnt_tens    (cnt_tens),
    .cnt_units   (cnt_units),
    .running     (running),
    .done        (done),
    .speaker     (speaker)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [10:0] val;
    logic [10:0] mask;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] pk(input int t, input int u, input int r, input int d, input int s);
    return {4'(t), 4'(u), 1'(r), 1'(d), 1'(s)};
  endfunction

  task automatic expect_at(input int unsigned c, input string tag, input logic [10:0] v,
                           input logic [10:0] m);
    exp_t e;
    e.cyc = c; e.tag = tag; e.val = v; e.mask = m;
    sb.push_back(e);
  endtask

  // Compares the observed outputs after edge N against entries scheduled for cycle N.
  always @(negedge clk) begin : mon
    exp_t e;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check({e.tag, "_late"}, 32'(cyc), 32'(e.cyc));
      else check(e.tag, 32'({cnt_tens, cnt_units, running, done, speaker} & e.mask),
                 32'(e.val & e.mask));
    end
  end

  task automatic load(input int t, input int u, input int et, input int eu, input string tag);
    @(negedge clk);
    ent_tens = 4'(t); ent_units = 4'(u); entry_ok = 1'b1;
    expect_at(cyc + 3, tag, pk(et, eu, 0, 0, 0), M_CR);
    repeat (4) @(negedge clk);
    entry_ok = 1'b0;
  endtask

  task automatic sp(output int unsigned e);
    @(negedge clk);
    start_pause = 1'b1; e = cyc + 1;
    @(negedge clk);
    start_pause = 1'b0;
  endtask

  task automatic clr(output int unsigned e);
    @(negedge clk);
    clear = 1'b1; e = cyc + 1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic errp(output int unsigned d);
    @(negedge clk);
    entry_err = 1'b1; d = cyc;
    @(negedge clk);
    entry_err = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk); #2; n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s, p, r, c, d, d2, q, q2;
    repeat (3) @(negedge clk);
    check("rst_cnt", 32'({cnt_tens, cnt_units}), 32'h00);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_speaker", 32'(speaker), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full countdown 03 -> 00 with alarm.
    load(0, 3, 0, 3, "t1_load");
    sp(s);
    expect_at(s,      "t1_start",     pk(0, 3, 1, 0, 0), M_ALL);
    expect_at(s + 3,  "t1_hold",      pk(0, 3, 1, 0, 0), M_ALL);
    expect_at(s + 4,  "t1_02",        pk(0, 2, 1, 0, 0), M_ALL);
    expect_at(s + 8,  "t1_01",        pk(0, 1, 1, 0, 0), M_ALL);
    expect_at(s + 11, "t1_pre00",     pk(0, 1, 1, 0, 0), M_ALL);
    expect_at(s + 12, "t1_00_done",   pk(0, 0, 0, 1, 1), M_ALL);
    expect_at(s + 13, "t1_done_once", pk(0, 0, 0, 0, 1), M_ALL);
    expect_at(s + 19, "t1_alarm_end", pk(0, 0, 0, 0, 1), M_ALL);
    expect_at(s + 20, "t1_idle",      pk(0, 0, 0, 0, 0), M_ALL);
    drain();

    // Reload while armed, then units borrow 10 -> 09.
    load(2, 7, 2, 7, "t2_load");
    load(1, 0, 1, 0, "t2_reload");
    sp(s);
    expect_at(s + 3, "t2_hold",   pk(1, 0, 1, 0, 0), M_ALL);
    expect_at(s + 4, "t2_borrow", pk(0, 9, 1, 0, 0), M_ALL);
    drain();
    clr(c);
    expect_at(c, "t2_clear", pk(0, 0, 0, 0, 0), M_ALL);
    drain();

    // Pause holds the prescaler; entry_ok in PAUSE is ignored.
    load(0, 5, 0, 5, "t3_load");
    sp(s);
    sp(p);
    expect_at(p, "t3_paused", pk(0, 5, 0, 0, 0), M_ALL);
    load(4, 2, 0, 5, "t3_ok_ignored");
    expect_at(p + 10, "t3_hold10", pk(0, 5, 0, 0, 0), M_ALL);
    expect_at(p + 20, "t3_hold20", pk(0, 5, 0, 0, 0), M_ALL);
    while (cyc < p + 19) @(negedge clk);
    sp(r);
    expect_at(r,     "t3_resume", pk(0, 5, 1, 0, 0), M_ALL);
    expect_at(r + 1, "t3_r1",     pk(0, 5, 1, 0, 0), M_ALL);
    expect_at(r + 2, "t3_dec",    pk(0, 4, 1, 0, 0), M_ALL);
    drain();
    clr(c);
    expect_at(c, "t3_clear", pk(0, 0, 0, 0, 0), M_ALL);
    drain();

    // Single error beep, then a restarted beep.
    errp(d);
    expect_at(d + 2, "t4_pre",  11'd0, M_SPK);
    expect_at(d + 3, "t4_on",   11'd1, M_SPK);
    expect_at(d + 8, "t4_last", 11'd1, M_SPK);
    expect_at(d + 9, "t4_off",  11'd0, M_SPK);
    drain();
    errp(d);
    expect_at(d + 2,  "t4b_pre",      11'd0, M_SPK);
    expect_at(d + 3,  "t4b_on",       11'd1, M_SPK);
    expect_at(d + 8,  "t4b_extended", 11'd1, M_SPK);
    expect_at(d + 9,  "t4b_mid",      11'd1, M_SPK);
    expect_at(d + 11, "t4b_last",     11'd1, M_SPK);
    expect_at(d + 12, "t4b_off",      11'd0, M_SPK);
    @(negedge clk);
    errp(d2);
    drain();

    // clear on the same cycle as a tick.
    load(0, 4, 0, 4, "t5_load");
    sp(s);
    expect_at(s + 3, "t5_pre", pk(0, 4, 1, 0, 0), M_ALL);
    while (cyc < s + 2) @(negedge clk);
    clr(c);
    expect_at(c,     "t5_clear_tick", pk(0, 0, 0, 0, 0), M_ALL);
    expect_at(c + 1, "t5_no_done",    pk(0, 0, 0, 0, 0), M_ALL);
    expect_at(c + 4, "t5_idle",       pk(0, 0, 0, 0, 0), M_ALL);
    drain();

    // Loaded 00 alarms at once; start_pause silences; IDLE ignores start_pause.
    load(0, 0, 0, 0, "t6_load");
    sp(s);
    expect_at(s,     "t6_zero_alarm", pk(0, 0, 0, 1, 1), M_ALL);
    expect_at(s + 1, "t6_alarm",      pk(0, 0, 0, 0, 1), M_ALL);
    sp(q);
    expect_at(q, "t6_silenced", pk(0, 0, 0, 0, 0), M_ALL);
    sp(q2);
    expect_at(q2, "t6_idle_ignores_sp", pk(0, 0, 0, 0, 0), M_ALL);
    drain();

    // Asynchronous reset in ALARM.
    load(0, 1, 0, 1, "t7_load");
    sp(s);
    expect_at(s + 4, "t7_alarm", pk(0, 0, 0, 1, 1), M_ALL);
    drain();
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("t7_rst_speaker", 32'(speaker), 32'd0);
    check("t7_rst_running", 32'(running), 32'd0);
    check("t7_rst_cnt", 32'({cnt_tens, cnt_units}), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    sp(q);
    expect_at(q, "t7_idle_after_rst", pk(0, 0, 0, 0, 0), M_ALL);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequences the countdown once the key reader has latched a valid two-digit BCD entry (01..50).
- Loads the entry, counts it down once per second, and supports start/pause and clear.
- Owns the single speaker line, arbitrating between a short error beep (invalid entry) and the end-of-count alarm.
- Sits between the key reader and the display/speaker drivers.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per 1 s tick; minimum 4.
- ERR_BEEP_CYC, 25_000_000, speaker-on cycles for one error beep.
- ALARM_SEC, 5, seconds the alarm sounds after reaching 00.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- entry_ok  in  1  key reader's valid-entry level (async domain)
- entry_err  in  1  key reader's invalid-entry level (async domain)
- ent_tens  in  4  latched tens digit, BCD 0..5
- ent_units  in  4  latched units digit, BCD 0..9
- start_pause  in  1  clean 1-cycle pulse, toggles run/pause
- clear  in  1  clean 1-cycle pulse, abort to IDLE
- cnt_tens  out  4  current tens digit
- cnt_units  out  4  current units digit
- running  out  1  high in RUN
- done  out  1  1-cycle pulse when the count reaches 00
- speaker  out  1  speaker drive

Behaviour:
- Reset: all outputs 0, state IDLE, prescaler 0, beep timer 0. clk and reset_n are fixed: one clock; reset asynchronous, active-low.
- Input sync: entry_ok and entry_err each pass through a 2-flop synchroniser, then a rising-edge detect.
  - Event reaches the FSM 3 cycles after the input edge.
  - ent_tens/ent_units are sampled on the same cycle as the entry_ok edge event.
- States: IDLE, ARMED, RUN, PAUSE, ALARM.
- IDLE:
  - entry_ok edge -> load digits into cnt_*, go to ARMED.
  - start_pause is ignored.
- ARMED:
  - start_pause -> RUN, prescaler cleared.
  - entry_ok edge -> reload digits, stay in ARMED.
- RUN:
  - Prescaler counts 0..CLK_DIV-1; on wrap the BCD count decrements.
  - Decrement rule: units 0 -> units 9 and tens-1; otherwise units-1.
  - When the decrement yields 00: done pulses on that cycle, go to ALARM.
  - start_pause -> PAUSE; the prescaler value is held, not cleared.
- PAUSE: start_pause -> RUN, resuming from the held prescaler value.
- ALARM:
  - speaker high for ALARM_SEC ticks, then IDLE with cnt_* left at 00.
  - start_pause silences the alarm immediately -> IDLE.
- clear: in any state -> IDLE on the next cycle; cnt_* = 0, speaker = 0, prescaler = 0. clear has priority over every simultaneous event.
- entry_ok edge in RUN, PAUSE or ALARM is ignored.
- Speaker arbitration:
  - ALARM has priority.
  - entry_err edge in any state other than ALARM starts an ERR_BEEP_CYC-cycle beep.
  - A new entry_err during a beep restarts the beep timer.
  - Entering ALARM aborts any error beep.
- Loaded digits are not range-checked again: the upstream reader guarantees 01..50. Defensively, a loaded 00 goes straight from ARMED to ALARM on start_pause, with done pulsing.
- Asynchronous reset mid-RUN returns to IDLE with the count lost.

Optional Feature:
- ALARM_PULSE_EN:
  - Defined: speaker in ALARM is gated by a 2 Hz square wave derived from the prescaler (on for the first and third quarters of each second). The error beep is unchanged.
  - Undefined: speaker is held steadily high in ALARM.

Decomposition:
- Package countdown_pkg:
  - state enum (IDLE, ARMED, RUN, PAUSE, ALARM)
  - 4-bit BCD digit typedef
  - constants BCD_MAX_UNITS=9 and ENTRY_MAX=8'h50
- Sub-module tick_prescaler:
  - Parameter CLK_DIV; inputs en, clr.
  - Outputs a 1-cycle tick pulse and a phase output for ALARM_PULSE_EN.

Test Plan (bench uses CLK_DIV=4, ERR_BEEP_CYC=6, ALARM_SEC=2):
- Load 0/3 via entry_ok, then start_pause -> running=1; count 03, 02, 01, 00 at 4-cycle intervals; done pulses once; speaker high for 8 cycles; then IDLE.
- Load 1/0, run one tick -> count 09 (units borrow wraps, tens decrements).
- Load 0/5, run 2 cycles, pause, wait 20 cycles, resume -> next decrement lands 2 cycles after resume; count holds at 05 while paused.
- entry_err edge in IDLE -> speaker high exactly 6 cycles, starting 3 cycles after the edge; a second edge mid-beep extends the beep to 6 cycles from the restart.
- clear asserted in RUN on the same cycle as a tick -> IDLE, cnt=00, no decrement, no done.
- reset_n low mid-ALARM -> speaker=0 and state IDLE asynchronously, before the next clk edge.
